// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and step-advance helper for led_sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ONESHOT  = 2'd0,
    LOOP     = 2'd1,
    PINGPONG = 2'd2
  } mode_e;

  // Widest step index the helper handles; callers zero-extend and truncate.
  localparam int MAX_STEP_W = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic [MAX_STEP_W-1:0] step;
    logic                  dir;
    logic                  wrap;
  } step_adv_t;

  // Next step/direction after a dwell expires; wrap marks a return to step 0.
  function automatic step_adv_t next_step(input logic [MAX_STEP_W-1:0] step,
                                          input logic                  dir,
                                          input logic [MAX_STEP_W-1:0] last,
                                          input mode_e                 mode);
    step_adv_t r;
    r.step = step + MAX_STEP_W'(1);
    r.dir  = dir;
    r.wrap = 1'b0;
    case (mode)
      PINGPONG: begin
        if (last == '0) begin
          // Single-step ping-pong just re-enters step 0 every pass.
          r.step = '0;
          r.dir  = DIR_UP;
          r.wrap = 1'b1;
        end else if (dir == DIR_DOWN || step == last) begin
          if (step <= MAX_STEP_W'(1)) begin
            r.step = '0;
            r.dir  = DIR_UP;
            r.wrap = 1'b1;
          end else begin
            r.step = step - MAX_STEP_W'(1);
            r.dir  = DIR_DOWN;
          end
        end
      end
      default: begin
        if (step == last) begin
          r.step = '0;
          r.wrap = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - push-button synchroniser and rising-edge pulse
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_btn_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Two-flop synchroniser followed by a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_btn_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - programmable LED step sequencer top level
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int NUM_STEPS = 4,
  parameter int DUR_WIDTH = 8,
  localparam int STEP_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [STEP_W-1:0]    last_step,
  input  logic                 cfg_we,
  input  logic [STEP_W-1:0]    cfg_addr,
  input  logic [NUM_CH-1:0]    cfg_pattern,
  input  logic [DUR_WIDTH-1:0] cfg_dur,
  output logic [NUM_CH-1:0]    leds,
  output logic                 busy,
  output logic [STEP_W-1:0]    step_idx,
  output logic                 done
);

  localparam logic [STEP_W-1:0] LAST_MAX = STEP_W'(NUM_STEPS - 1);

  logic [NUM_CH-1:0]    r_pat [NUM_STEPS];
  logic [DUR_WIDTH-1:0] r_dur [NUM_STEPS];

  state_e               r_state;
  state_e               w_state_nxt;
  logic [STEP_W-1:0]    r_step;
  logic [STEP_W-1:0]    w_step_nxt;
  logic                 r_dir;
  logic                 w_dir_nxt;
  logic [DUR_WIDTH-1:0] r_cnt;
  logic [DUR_WIDTH-1:0] w_cnt_nxt;
  mode_e                r_mode;
  mode_e                w_mode_sel;
  logic [STEP_W-1:0]    r_last;
  logic [STEP_W-1:0]    w_last_clamped;
  logic                 w_capture;
  logic                 w_wrap;
  logic                 w_expire;
  logic                 w_btn_rise;
  step_adv_t            w_adv;

  logic [NUM_CH-1:0]    r_leds;
  logic                 r_busy;
  logic                 r_done;

  button_edge u_button_edge (
    .clk        (clk),
    .reset      (reset),
    .i_button   (button),
    .o_btn_rise (w_btn_rise)
  );

  assign w_expire       = (r_cnt == r_dur[r_step]);
  assign w_last_clamped = (last_step > LAST_MAX) ? LAST_MAX : last_step;
  assign w_adv          = next_step(MAX_STEP_W'(r_step), r_dir,
                                    MAX_STEP_W'(r_last), r_mode);

  // Reserved mode encoding plays back as one-shot.
  always_comb begin
    w_mode_sel = ONESHOT;
    case (mode)
      2'd1:    w_mode_sel = LOOP;
      2'd2:    w_mode_sel = PINGPONG;
      default: w_mode_sel = ONESHOT;
    endcase
  end

  // Step table: writable only while idle, out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_pat[i] <= '0;
        r_dur[i] <= '0;
      end
    end else if (r_state == IDLE && cfg_we && cfg_addr <= LAST_MAX) begin
      r_pat[cfg_addr] <= cfg_pattern;
      r_dur[cfg_addr] <= cfg_dur;
    end
  end

  // Next-state, step, direction and dwell counter; stop has top priority.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    w_capture   = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_step_nxt  = '0;
      w_dir_nxt   = DIR_UP;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_btn_rise) begin
            w_state_nxt = RUN;
            w_step_nxt  = '0;
            w_dir_nxt   = DIR_UP;
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
          end
        end
        RUN: begin
          if (w_btn_rise) begin
            // Pause wins over expiry; a terminal count is held so the
            // advance happens on the first cycle after resume.
            w_state_nxt = PAUSE;
            if (!w_expire) begin
              w_cnt_nxt = r_cnt + DUR_WIDTH'(1);
            end
          end else if (w_expire) begin
            w_cnt_nxt  = '0;
            w_step_nxt = STEP_W'(w_adv.step);
            w_dir_nxt  = w_adv.dir;
            w_wrap     = w_adv.wrap;
            if (w_adv.wrap && r_mode == ONESHOT) begin
              w_state_nxt = IDLE;
              w_step_nxt  = '0;
              w_dir_nxt   = DIR_UP;
            end
          end else begin
            w_cnt_nxt = r_cnt + DUR_WIDTH'(1);
          end
        end
        PAUSE: begin
          if (w_btn_rise) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = state_e'(2'bxx);
        end
      endcase
    end
  end

  // Sequencer state registers plus mode/last-step captured at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
      r_mode  <= ONESHOT;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_mode <= w_mode_sel;
        r_last <= w_last_clamped;
      end
    end
  end

  // Outputs registered from next-state values so they move with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_leds <= (w_state_nxt == IDLE) ? '0 : r_pat[w_step_nxt];
      r_busy <= (w_state_nxt != IDLE);
      r_done <= w_wrap;
    end
  end

  assign leds     = r_leds;
  assign busy     = r_busy;
  assign step_idx = r_step;
  assign done     = r_done;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer
module tb_led_sequencer;

  logic       clk;
  logic       reset;
  logic       button;
  logic       stop;
  logic [1:0] mode;
  logic [1:0] last_step;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_pattern;
  logic [7:0] cfg_dur;
  logic [2:0] leds;
  logic       busy;
  logic [1:0] step_idx;
  logic       done;
  logic [2:0] leds3;
  logic       busy3;
  logic [1:0] step_idx3;
  logic       done3;

  int total = 0;
  int bad   = 0;

  logic [2:0] os_leds  [11] = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b010, 3'b010,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
  logic [1:0] pp_steps [8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
  logic [2:0] rs_leds  [6]  = '{3'b011, 3'b011, 3'b011, 3'b010, 3'b100, 3'b000};
  logic [2:0] cl_leds  [4]  = '{3'b001, 3'b011, 3'b010, 3'b000};

  led_sequencer #(.NUM_CH(3), .NUM_STEPS(4), .DUR_WIDTH(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .stop        (stop),
    .mode        (mode),
    .last_step   (last_step),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .cfg_dur     (cfg_dur),
    .leds        (leds),
    .busy        (busy),
    .step_idx    (step_idx),
    .done        (done)
  );

  led_sequencer #(.NUM_CH(3), .NUM_STEPS(3), .DUR_WIDTH(8)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .stop        (stop),
    .mode        (mode),
    .last_step   (last_step),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .cfg_dur     (cfg_dur),
    .leds        (leds3),
    .busy        (busy3),
    .step_idx    (step_idx3),
    .done        (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [2:0] p, input logic [7:0] d);
    logic [31:0] av;
    av          = a;
    cfg_we      = 1'b1;
    cfg_addr    = av[1:0];
    cfg_pattern = p;
    cfg_dur     = d;
    tick();
    cfg_we      = 1'b0;
  endtask

  // One-cycle button pulse; returns with the first RUN cycle visible.
  task automatic press();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; button = 1'b0; stop = 1'b0; mode = 2'd0; last_step = 2'd0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_pattern = 3'd0; cfg_dur = 8'd0;
    tick();
    tick();
    chk("rst_leds", leds, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_step", step_idx, 2'd0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    tick();

    // One-shot through all four steps.
    wr(0, 3'b001, 8'd2); wr(1, 3'b011, 8'd0); wr(2, 3'b010, 8'd1); wr(3, 3'b100, 8'd3);
    mode = 2'd0; last_step = 2'd3;
    press();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      chk($sformatf("os_leds[%0d]", i), leds, os_leds[i]);
      chk($sformatf("os_done[%0d]", i), done, (i == 10));
      chk($sformatf("os_busy[%0d]", i), busy, (i != 10));
    end
    tick();
    chk("os_done_clear", done, 1'b0);

    // Loop over steps 0..1, then stop mid-wrap.
    mode = 2'd1; last_step = 2'd1;
    press();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("lp_leds[%0d]", i), leds, ((i % 4) == 3) ? 3'b011 : 3'b001);
      chk($sformatf("lp_done[%0d]", i), done, (i == 4 || i == 8));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("lp_stop_leds", leds, 3'b000);
    chk("lp_stop_busy", busy, 1'b0);
    chk("lp_stop_done", done, 1'b0);
    chk("lp_stop_step", step_idx, 2'd0);

    // Ping-pong with zero dwell.
    wr(0, 3'b001, 8'd0); wr(1, 3'b011, 8'd0); wr(2, 3'b010, 8'd0); wr(3, 3'b100, 8'd0);
    mode = 2'd2; last_step = 2'd3;
    press();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk($sformatf("pp_step[%0d]", i), step_idx, pp_steps[i]);
      chk($sformatf("pp_done[%0d]", i), done, (i == 6));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pp_stop_busy", busy, 1'b0);

    // Pause mid-step 1 for ten cycles.
    wr(0, 3'b001, 8'd4); wr(1, 3'b011, 8'd3); wr(2, 3'b010, 8'd0); wr(3, 3'b100, 8'd0);
    mode = 2'd0; last_step = 2'd3;
    press();
    tick();
    tick();
    tick();
    button = 1'b1;
    tick();
    button = 1'b0;
    chk("pz_c4_leds", leds, 3'b001);
    tick();
    chk("pz_c5_leds", leds, 3'b011);
    chk("pz_c5_step", step_idx, 2'd1);
    tick();
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("pz_hold_leds[%0d]", i), leds, 3'b011);
      chk($sformatf("pz_hold_step[%0d]", i), step_idx, 2'd1);
      chk($sformatf("pz_hold_busy[%0d]", i), busy, 1'b1);
      button = (i == 8);
      tick();
    end
    button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk($sformatf("pz_res_leds[%0d]", i), leds, rs_leds[i]);
      chk($sformatf("pz_res_done[%0d]", i), done, (i == 5));
    end
    tick();

    // Pause on the dwell-expiry cycle; attempt a table write while busy.
    press();
    tick();
    tick();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    chk("ex_c4_leds", leds, 3'b001);
    tick();
    chk("ex_p1_leds", leds, 3'b001);
    chk("ex_p1_step", step_idx, 2'd0);
    button = 1'b1;
    wr(0, 3'b111, 8'd0);
    button = 1'b0;
    chk("ex_p2_leds", leds, 3'b001);
    tick();
    chk("ex_p3_leds", leds, 3'b001);
    tick();
    chk("ex_r1_leds", leds, 3'b001);
    chk("ex_r1_step", step_idx, 2'd0);
    tick();
    chk("ex_r2_leds", leds, 3'b011);
    chk("ex_r2_step", step_idx, 2'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ex_stop_busy", busy, 1'b0);

    // Table must be unchanged by the busy write.
    press();
    chk("we_c0_leds", leds, 3'b001);
    tick(); tick(); tick(); tick();
    chk("we_c4_leds", leds, 3'b001);
    tick();
    chk("we_c5_leds", leds, 3'b011);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Three-step instance: addr 3 dropped, last_step 3 clamped to 2.
    wr(0, 3'b001, 8'd0); wr(1, 3'b011, 8'd0); wr(2, 3'b010, 8'd0); wr(3, 3'b111, 8'd0);
    mode = 2'd0; last_step = 2'd3;
    press();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("cl_leds[%0d]", i), leds3, cl_leds[i]);
      chk($sformatf("cl_done[%0d]", i), done3, (i == 3));
    end
    chk("cl_busy_end", busy3, 1'b0);
    tick();
    tick();

    // Asynchronous reset during step 2.
    wr(2, 3'b010, 8'd5);
    mode = 2'd0; last_step = 2'd3;
    press();
    tick();
    tick();
    chk("rs_pre_step", step_idx, 2'd2);
    chk("rs_pre_leds", leds, 3'b010);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_leds", leds, 3'b000);
    chk("rs_busy", busy, 1'b0);
    chk("rs_step", step_idx, 2'd0);
    chk("rs_done", done, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    chk("rs_idle_busy", busy, 1'b0);
    press();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("rz_leds[%0d]", i), leds, 3'b000);
      chk($sformatf("rz_busy[%0d]", i), busy, (i != 4));
      chk($sformatf("rz_done[%0d]", i), done, (i == 4));
      if (i < 4) chk($sformatf("rz_step[%0d]", i), step_idx, i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised, programmable LED step sequencer for the board-level status/indicator path. It drives NUM_CH registered LED outputs through up to NUM_STEPS table-defined patterns, each held for a programmable dwell. A synchronised push-button starts, pauses and resumes the sequence. The block supports one-shot, loop and ping-pong playback.

## Interface
- NUM_CH, 3: number of LED output channels.
- NUM_STEPS, 4: depth of the step table (≥1).
- DUR_WIDTH, 8: width of a per-step dwell value.
- STEP_W (localparam): $clog2(NUM_STEPS), minimum 1.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- button  in  1  raw asynchronous push-button, active-high.
- stop  in  1  synchronous abort to IDLE.
- mode  in  2  playback mode: 0 ONESHOT, 1 LOOP, 2 PINGPONG, 3 reserved (treated as ONESHOT).
- last_step  in  STEP_W  index of the final active step; values ≥NUM_STEPS are clamped to NUM_STEPS-1.
- cfg_we  in  1  step-table write strobe.
- cfg_addr  in  STEP_W  step-table write index; out-of-range writes are dropped.
- cfg_pattern  in  NUM_CH  LED pattern for the step.
- cfg_dur  in  DUR_WIDTH  dwell; the step lasts cfg_dur+1 cycles.
- leds  out  NUM_CH  registered LED drive.
- busy  out  1  high in RUN or PAUSE.
- step_idx  out  STEP_W  registered index of the current step (0 in IDLE).
- done  out  1  one-cycle pulse at the end of a sequence pass.

## Operation
- States: IDLE, RUN, PAUSE.
- The step table (pattern, dur) holds NUM_STEPS entries and resets to all zeros. cfg_we is honoured only in IDLE and ignored otherwise.
- mode and last_step are captured at start and held until the block returns to IDLE.
- btn_rise is a one-cycle pulse produced from the 2-flop-synchronised button.
- IDLE -> RUN on btn_rise. Entering RUN sets step 0 and clears the counter.
- RUN:
  - The counter increments each cycle.
  - When counter == dur[step], the step advances and the counter clears.
  - A btn_rise in RUN -> PAUSE.
- PAUSE: counter, step and leds are frozen. A btn_rise in PAUSE -> RUN.
- Advance rules:
  - ONESHOT: step+1. After last_step, -> IDLE with done=1.
  - LOOP: last_step wraps to 0 with done=1.
  - PINGPONG: direction flips at last_step and at 0. End steps are not repeated. done=1 on each return to step 0. With last_step=0 the block holds step 0 and pulses done every dur[0]+1 cycles.
- stop=1 in any state -> IDLE at the next edge. No done pulse is generated.
- Priorities:
  - stop beats btn_rise and beats dwell expiry.
  - In RUN, btn_rise beats dwell expiry. The block pauses with the counter at its terminal value, and the advance occurs on the first RUN cycle after resume.
- leds = pattern[step] in RUN and PAUSE, and 0 in IDLE.
- Outputs are registered from next-state, next-step values so they change on the same edge as the state.

## Timing
- Reset values: state IDLE, counter 0, step 0, direction up, leds 0, busy 0, step_idx 0, done 0, synchroniser flops 0, table all 0.
- Button latency: if button goes high before edge 0, btn_rise is asserted after edge 1. State, busy and leds=pattern[0] update at edge 2.
- A step with dur=d holds its pattern for exactly d+1 cycles in RUN. Paused cycles are not counted.
- done is asserted in the same cycle in which leds/step_idx first show the post-wrap value, or in the cycle in which leds=0 for ONESHOT.
- stop asserted before edge n gives busy=0 and leds=0 after edge n.
- A reset asserted mid-sequence clears all state immediately (asynchronous). There is no done pulse.
- Counter arithmetic is DUR_WIDTH unsigned with no wrap. The comparison is an equality with the stored dur.

## Structure
- Package led_seq_pkg contains:
  - state_e (IDLE, RUN, PAUSE, with 'x default for the next-state assignment);
  - mode_e (ONESHOT, LOOP, PINGPONG);
  - function next_step(step, dir, last, mode) returning the next step, the next direction and a wrap flag.
- Sub-module button_edge contains the 2-flop synchroniser, a previous-value flop and btn_rise. It is instantiated once.
- The top level contains the table registers, the FSM, the dwell counter and the output registers.

## Test plan
- Program steps 0..3 as patterns 001/011/010/100 with dur 2,0,1,3. Use ONESHOT, last_step=3, and apply a button pulse. Required: leds 001×3, 011×1, 010×2 and 100×4 cycles, then 0. done fires once and busy falls on the same edge.
- Same table in LOOP with last_step=1. Required: the pattern repeats 001,001,001,011. done fires every 4 cycles. After 3 passes assert stop: leds=0 at the next edge and no done.
- PINGPONG, last_step=3, all dur=0. Required: step_idx runs 0,1,2,3,2,1,0,1 and done fires each time step 0 is re-entered.
- Apply button mid-step 1 (counter=0, dur=3) to pause for 10 cycles, then press again. Required: leds hold 011 while paused and step 1 totals 4 RUN cycles. Pressing on the dwell-expiry cycle pauses before the advance.
- Issue cfg_we while busy (addr 0, pattern 111). Required: the table is unchanged. cfg_addr=NUM_STEPS and last_step=NUM_STEPS+1 are clamped or dropped as specified.
- Assert reset during RUN step 2. Required: all outputs 0 immediately, and the table reads back all zeros on the next run.
